// File: rtl/cr_kme_fifo_arb_if.sv
// cr_kme_fifo_arb_if
// Bundles the upstream FIFO read ports, the downstream FIFO write port and the
// arbitration config/status of cr_kme_fifo_arb.
//   in_data   N_PORTS*DATA_SIZE  per-port head payload, port i at [i*DATA_SIZE +: DATA_SIZE]
//   in_eop    N_PORTS            per-port end-of-packet flag
//   in_valid  N_PORTS            per-port upstream FIFO not empty
//   in_ack    N_PORTS            per-port pop, at most one bit set
//   port_en   N_PORTS            per-port arbitration enable
//   out_stall 1                  downstream full, no beat accepted while high
//   out_data  DATA_SIZE          registered payload
//   out_eop   1                  registered eop
//   out_port  PTR_W              registered source port of the beat
//   out_valid 1                  registered downstream write strobe
//   busy      1                  high while locked mid-packet
// master: the side driving the FIFOs/config (requesters + downstream);
// slave: the arbiter.
interface cr_kme_fifo_arb_if #(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned PTR_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
);
    logic [N_PORTS*DATA_SIZE-1:0] in_data;
    logic [N_PORTS-1:0]           in_eop;
    logic [N_PORTS-1:0]           in_valid;
    logic [N_PORTS-1:0]           in_ack;
    logic [N_PORTS-1:0]           port_en;
    logic                         out_stall;
    logic [DATA_SIZE-1:0]         out_data;
    logic                         out_eop;
    logic [PTR_W-1:0]             out_port;
    logic                         out_valid;
    logic                         busy;

    modport master (
        output in_data, in_eop, in_valid, port_en, out_stall,
        input  in_ack, out_data, out_eop, out_port, out_valid, busy
    );

    modport slave (
        input  in_data, in_eop, in_valid, port_en, out_stall,
        output in_ack, out_data, out_eop, out_port, out_valid, busy
    );
endinterface

// File: rtl/cr_kme_fifo_arb.sv
// cr_kme_fifo_arb
// Packet-aware round-robin arbiter: drains N_PORTS upstream FIFO read ports
// (valid/ack) into one downstream FIFO write port (valid/stall). Whole packets,
// delimited by eop, are kept contiguous downstream.
//   clk     clock
//   rst     synchronous active-high reset
//   arb_bus cr_kme_fifo_arb_if.slave: in_data/in_eop/in_valid/port_en/out_stall in,
//           in_ack (combinational) and out_data/out_eop/out_port/out_valid/busy out
module cr_kme_fifo_arb #(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned DATA_SIZE = 10
) (
    input  logic             clk,
    input  logic             rst,
    cr_kme_fifo_arb_if.slave arb_bus
);
    localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e               r_state, w_state_d;
    logic [PTR_W-1:0]     r_rr_ptr, w_rr_ptr_d;
    logic [PTR_W-1:0]     r_lock_port, w_lock_port_d;

    logic                 r_out_valid;
    logic [DATA_SIZE-1:0] r_out_data;
    logic                 r_out_eop;
    logic [PTR_W-1:0]     r_out_port;

    logic [DATA_SIZE-1:0] w_port_data [N_PORTS];
    logic                 w_grant;
    logic [PTR_W-1:0]     w_grant_idx;
    logic [PTR_W-1:0]     w_cand;
    logic [PTR_W-1:0]     w_grant_next;
    logic [DATA_SIZE-1:0] w_grant_data;
    logic                 w_grant_eop;
    logic [N_PORTS-1:0]   w_ack;

    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_port_data[i] = arb_bus.in_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Grant selection. Stall is sampled in the same cycle as the decision, so
    // at most one beat can still land after out_stall rises.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (!rst && !arb_bus.out_stall) begin
            if (r_state == StLocked) begin
                // port_en is ignored here so a started packet always completes
                w_grant     = arb_bus.in_valid[r_lock_port];
                w_grant_idx = r_lock_port;
            end else begin
                for (int unsigned k = 0; k < N_PORTS; k++) begin
                    w_cand = PTR_W'((32'(r_rr_ptr) + k) % N_PORTS);
                    if (!w_grant && arb_bus.in_valid[w_cand] && arb_bus.port_en[w_cand]) begin
                        w_grant     = 1'b1;
                        w_grant_idx = w_cand;
                    end
                end
            end
        end
    end

    always_comb begin
        w_grant_data = w_port_data[w_grant_idx];
        w_grant_eop  = arb_bus.in_eop[w_grant_idx];
        w_grant_next = (w_grant_idx == PTR_W'(N_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
        w_ack        = '0;
        if (w_grant) begin
            w_ack[w_grant_idx] = 1'b1;
        end
    end

    // Next-state: an eop beat always returns to idle and advances the pointer
    // past the granted port; a non-eop beat locks onto it.
    always_comb begin
        w_state_d     = r_state;
        w_rr_ptr_d    = r_rr_ptr;
        w_lock_port_d = r_lock_port;
        if (w_grant) begin
            if (w_grant_eop) begin
                w_state_d  = StIdle;
                w_rr_ptr_d = w_grant_next;
            end else begin
                w_state_d     = StLocked;
                w_lock_port_d = w_grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_rr_ptr    <= '0;
            r_lock_port <= '0;
        end else begin
            r_state     <= w_state_d;
            r_rr_ptr    <= w_rr_ptr_d;
            r_lock_port <= w_lock_port_d;
        end
    end

    // Output stage: payload registers hold their value when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
            r_out_port  <= '0;
        end else begin
            r_out_valid <= w_grant;
            if (w_grant) begin
                r_out_data <= w_grant_data;
                r_out_eop  <= w_grant_eop;
                r_out_port <= w_grant_idx;
            end
        end
    end

    assign arb_bus.in_ack    = w_ack;
    assign arb_bus.out_valid = r_out_valid;
    assign arb_bus.out_data  = r_out_data;
    assign arb_bus.out_eop   = r_out_eop;
    assign arb_bus.out_port  = r_out_port;
    assign arb_bus.busy      = (r_state == StLocked);
endmodule

// File: doc/cr_kme_fifo_arb.md
Name: cr_kme_fifo_arb

Overview:
- Packet-aware round-robin arbiter that drains N_PORTS upstream FIFO read ports into a single downstream FIFO write port.
- It sits between several per-requester kme FIFOs (valid/ack read side) and one shared downstream FIFO (valid/stall write side).
- It serialises whole packets, delimited by eop, so beats from different requesters never interleave downstream.

Parameters:
- N_PORTS, 4, number of requester ports (legal range 1..16).
- DATA_SIZE, 10, payload width per beat, excluding eop.
- PTR_W, derived as max(1, clog2(N_PORTS)); width of port index and round-robin pointer.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_PORTS*DATA_SIZE  per-port payload. Port i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- in_eop  input  N_PORTS  per-port end-of-packet flag, qualified by in_valid.
- in_valid  input  N_PORTS  per-port head-of-FIFO valid (upstream FIFO not empty).
- in_ack  output  N_PORTS  per-port pop; at most one bit set per cycle.
- port_en  input  N_PORTS  per-port arbitration enable (quasi-static config).
- out_stall  input  1  downstream full/almost-full; no beat is accepted while high.
- out_data  output  DATA_SIZE  registered payload.
- out_eop  output  1  registered eop.
- out_port  output  PTR_W  registered source port index of the current beat.
- out_valid  output  1  registered write strobe to the downstream FIFO.
- busy  output  1  high while locked mid-packet.

Behaviour:
- Reset (rst=1 at a clk edge) sets the following:
  - out_valid=0, out_data=0, out_eop=0, out_port=0.
  - state=IDLE, rr_ptr=0, lock_port=0, busy=0.
  - in_ack is 0 in every cycle in which rst=1.
- Reset mid-packet abandons the packet. Arbitration restarts from port 0 in IDLE, and no flush is emitted downstream.
- in_ack is combinational from state, rr_ptr, lock_port, in_valid, port_en and out_stall. Upstream pops when in_valid[i] & in_ack[i].
- in_ack is never asserted for a port whose in_valid is low.
- Latency is 1 cycle. When in_ack[i]=1 in cycle t, then in cycle t+1:
  - out_valid=1;
  - out_data and out_eop carry port i's beat;
  - out_port=i.
  - If no ack occurs in cycle t, out_valid=0 in t+1 and out_data/out_eop/out_port hold their previous values.
- out_stall is sampled in the same cycle as the ack decision. One beat may therefore be in flight after stall rises, so the downstream FIFO must be configured with at least 1 slot of stall headroom.
- Throughput is one beat per cycle when not stalled.
- State IDLE (busy=0):
  - If out_stall=1, there is no grant.
  - Otherwise grant the first port p, searched in order rr_ptr, rr_ptr+1, ..., modulo N_PORTS, that has in_valid[p] & port_en[p].
  - If the granted beat has eop=1, stay in IDLE and set rr_ptr=(p+1) mod N_PORTS.
  - If eop=0, set lock_port=p and go to LOCKED.
  - If no port is eligible, there is no grant and rr_ptr is unchanged.
- State LOCKED (busy=1):
  - Only lock_port can be granted; in_ack[lock_port] = in_valid[lock_port] & !out_stall.
  - port_en[lock_port] is ignored while locked, so a packet always completes.
  - All other ports are blocked even if valid, including while lock_port has bubbles.
  - A beat with eop=1 returns the block to IDLE with rr_ptr=(lock_port+1) mod N_PORTS.
  - The next grant can occur the cycle after the eop beat is acked.
- rr_ptr wraps from N_PORTS-1 to 0. With N_PORTS=1, rr_ptr and out_port are constant 0.
- The eop of the granted beat is taken from in_eop[granted] in the same cycle as the ack.
- There is no timeout. A locked port that never sends eop blocks forever; this is by design and the requester is responsible for it.

Test Plan:
- Reset, then all 4 ports hold continuous single-beat (eop=1) packets with data=0x10+i, port_en=4'hF, out_stall=0:
  - in_ack one-hot in the sequence 1,2,4,8,1,...;
  - out_valid=1 every cycle from the 2nd cycle on;
  - out_port sequence 0,1,2,3,0;
  - out_data matches the source port with 1-cycle latency.
- Port 1 sends a 3-beat packet (eop on beat 3) while port 2 is valid:
  - three consecutive acks to port 1 with busy=1 during beats 1-2;
  - port 2 is acked the next cycle and rr_ptr goes 2 then 3.
- Port 1 is locked and drops in_valid for 2 cycles while port 3 is valid:
  - in_ack=0 for those 2 cycles and out_valid=0 one cycle later;
  - port 3 is not served until port 1's eop beat has been acked.
- out_stall=1 for 3 cycles mid-packet:
  - in_ack=0 and busy stays 1;
  - after release the same port resumes, with no duplicated or dropped beats (compare against a scoreboard of sent beats).
- port_en=4'b1010 with all ports valid, single-beat packets:
  - only ports 1 and 3 are acked, alternating 1,3,1,3;
  - port_en cleared for port 1 while it is locked still lets its packet finish.
- rst pulsed while LOCKED on port 2:
  - in_ack=0 during the reset cycle;
  - next cycle out_valid=0, busy=0;
  - first grant afterwards goes to the lowest valid enabled port starting from 0.
